multi_line_buf: RTL and testbench

MULTI_LINE_BUF -- requirements
Module: multi_line_buf

---
 rtl/multi_line_buf_if.sv | 13 +
 rtl/multi_line_buf.sv | 167 ++++++++++++++++
 tb/tb_multi_line_buf.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_line_buf_if.sv
// AXI4-Stream video bus: tuser marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic                   tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/multi_line_buf.sv
// Multi-slot video line buffer: whole lines are written into a ring of slots and streamed out on pop.
// First output beat 2 cycles after pop, gapless under tready; input stalls while all slots are full.
module multi_line_buf #(
  parameter int MAX_LINE_SIZE = 1920,
  parameter int LINES_CNT     = 4,
  parameter int TDATA_WIDTH   = 32,
  parameter int PX_WIDTH      = 30,
  parameter int AUTO_POP      = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           pop_line_i,
  input  logic                           drop_line_i,
  axi4_stream_if.slave                   video_i,
  axi4_stream_if.master                  video_o,
  output logic [$clog2(LINES_CNT+1)-1:0] lines_o,
  output logic                           full_o,
  output logic                           empty_o
);
  localparam int DEPTH  = LINES_CNT * MAX_LINE_SIZE;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SLOT_W = $clog2(LINES_CNT);
  localparam int LEN_W  = $clog2(MAX_LINE_SIZE + 1);
  localparam int CNT_W  = $clog2(LINES_CNT + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  logic [PX_WIDTH-1:0] mem [DEPTH];
  logic [PX_WIDTH-1:0] rd_q;
  logic [LEN_W-1:0]    line_len [LINES_CNT];
  logic                line_sof [LINES_CNT];

  state_t            state;
  logic [SLOT_W-1:0] wr_slot, rd_slot, wr_slot_eff;
  logic [LEN_W-1:0]  wr_idx, wr_idx_eff, wr_idx_sat, rd_idx, rd_len;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [CNT_W-1:0]  lines_q;
  logic              wr_sof, wr_sof_eff, rd_sof;
  logic              out_vld, out_last, out_user;
  logic              beat_acc, sof_acc, eol_acc, wr_en;
  logic              rd_adv, rd_last, rd_done, drop_ok, pop_ok, rd_free;
  logic              unused_tdata;

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return (s == SLOT_W'(LINES_CNT - 1)) ? '0 : s + SLOT_W'(1);
  endfunction

  assign beat_acc = video_i.tvalid && video_i.tready;
  assign sof_acc  = beat_acc && video_i.tuser;
  assign eol_acc  = beat_acc && video_i.tlast;

  // A start-of-frame beat restarts the ring: it always lands at slot 0, pixel 0.
  assign wr_slot_eff = sof_acc ? '0 : wr_slot;
  assign wr_idx_eff  = sof_acc ? '0 : wr_idx;
  assign wr_sof_eff  = sof_acc ? 1'b1 : wr_sof;
  assign wr_idx_sat  = (wr_idx_eff == LEN_W'(MAX_LINE_SIZE)) ? wr_idx_eff : wr_idx_eff + LEN_W'(1);
  assign wr_en       = beat_acc && (wr_idx_eff != LEN_W'(MAX_LINE_SIZE));
  assign wr_addr     = ADDR_W'(wr_slot_eff) * ADDR_W'(MAX_LINE_SIZE) + ADDR_W'(wr_idx_eff);

  assign rd_len  = line_len[rd_slot];
  assign rd_sof  = line_sof[rd_slot];
  assign rd_adv  = (state == READ) && (!out_vld || video_o.tready);
  assign rd_last = (rd_idx == rd_len - LEN_W'(1));
  assign rd_addr = ADDR_W'(rd_slot) * ADDR_W'(MAX_LINE_SIZE) + ADDR_W'(rd_idx);
  assign rd_done = (state == DRAIN) && out_vld && video_o.tready;
  assign drop_ok = (state == IDLE) && drop_line_i && !empty_o;
  assign pop_ok  = (state == IDLE) && !drop_line_i && (pop_line_i || (AUTO_POP != 0)) && !empty_o;
  assign rd_free = rd_done || drop_ok;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= video_i.tdata[PX_WIDTH-1:0];
    if (rd_adv) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (eol_acc) begin
      line_len[wr_slot_eff] <= wr_idx_sat;
      line_sof[wr_slot_eff] <= wr_sof_eff;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_slot <= '0;
      wr_idx  <= '0;
      wr_sof  <= 1'b0;
    end else if (beat_acc) begin
      if (video_i.tlast) begin
        wr_slot <= slot_inc(wr_slot_eff);
        wr_idx  <= '0;
        wr_sof  <= 1'b0;
      end else begin
        wr_slot <= wr_slot_eff;
        wr_idx  <= wr_idx_sat;
        wr_sof  <= wr_sof_eff;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lines_q <= '0;
    end else if (sof_acc) begin
      lines_q <= video_i.tlast ? CNT_W'(1) : '0;
    end else if (eol_acc && !rd_free) begin
      lines_q <= lines_q + CNT_W'(1);
    end else if (!eol_acc && rd_free) begin
      lines_q <= lines_q - CNT_W'(1);
    end
  end

  // The RAM output register is the output stage: reads are only issued when it can move.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rd_slot  <= '0;
      rd_idx   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_user <= 1'b0;
    end else if (sof_acc) begin
      state    <= IDLE;
      rd_slot  <= '0;
      rd_idx   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_user <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_idx <= '0;
          if (drop_ok) rd_slot <= slot_inc(rd_slot);
          else if (pop_ok) state <= READ;
        end
        READ: begin
          if (rd_adv) begin
            rd_idx   <= rd_idx + LEN_W'(1);
            out_vld  <= 1'b1;
            out_last <= rd_last;
            out_user <= (rd_idx == '0) && rd_sof;
            if (rd_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_done) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_user <= 1'b0;
            rd_slot  <= slot_inc(rd_slot);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign video_i.tready = !full_o;
  assign video_o.tvalid = out_vld;
  assign video_o.tdata  = TDATA_WIDTH'(rd_q);
  assign video_o.tlast  = out_last;
  assign video_o.tuser  = out_user;
  assign lines_o        = lines_q;
  assign full_o         = (lines_q == CNT_W'(LINES_CNT));
  assign empty_o        = (lines_q == '0);
  assign unused_tdata   = ^video_i.tdata;
endmodule

// File: tb/tb_multi_line_buf.sv
// Scoreboard bench for multi_line_buf: one manual-pop and one auto-pop instance.
module tb_multi_line_buf;
  localparam int MAXL = 16;
  localparam int NL   = 4;
  localparam int TW   = 32;
  localparam int PW   = 30;
  localparam int CW   = $clog2(NL + 1);

  logic clk;
  logic rst, pop, drop, a_pop, a_drop;
  logic [CW-1:0] lines, a_lines;
  logic full, empty, a_full, a_empty;
  int   rdy_mode;
  int   total, bad;
  logic [33:0] exp_q[$];
  logic [33:0] a_exp_q[$];

  axi4_stream_if #(.TDATA_WIDTH(TW)) vi ();
  axi4_stream_if #(.TDATA_WIDTH(TW)) vo ();
  axi4_stream_if #(.TDATA_WIDTH(TW)) a_vi ();
  axi4_stream_if #(.TDATA_WIDTH(TW)) a_vo ();

  multi_line_buf #(.MAX_LINE_SIZE(MAXL), .LINES_CNT(NL), .TDATA_WIDTH(TW), .PX_WIDTH(PW), .AUTO_POP(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .pop_line_i(pop), .drop_line_i(drop),
    .video_i(vi), .video_o(vo), .lines_o(lines), .full_o(full), .empty_o(empty));

  multi_line_buf #(.MAX_LINE_SIZE(MAXL), .LINES_CNT(NL), .TDATA_WIDTH(TW), .PX_WIDTH(PW), .AUTO_POP(1)) u_auto (
    .clk_i(clk), .rst_i(rst), .pop_line_i(a_pop), .drop_line_i(a_drop),
    .video_i(a_vi), .video_o(a_vo), .lines_o(a_lines), .full_o(a_full), .empty_o(a_empty));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] exp_beat(input logic [31:0] d, input bit last, input bit user);
    logic [31:0] z;
    z = '0;
    z[PW-1:0] = d[PW-1:0];
    return {user, last, z};
  endfunction

  initial begin
    vo.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       vo.tready = 1'b0;
        1:       vo.tready = 1'b1;
        default: vo.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: compare every accepted beat against the scoreboard, and hold-stability while stalled.
  initial begin
    logic [33:0] held, got, e;
    bit hv;
    hv = 0;
    forever begin
      @(negedge clk);
      got = {vo.tuser, vo.tlast, vo.tdata};
      if (rst) begin
        hv = 0;
      end else begin
        if (hv && vo.tvalid) check("stall_stable", got, held);
        if (vo.tvalid && vo.tready) begin
          if (exp_q.size() != 0) e = exp_q.pop_front();
          else e = '1;
          check("out_beat", got, e);
        end
        hv = vo.tvalid && !vo.tready;
        held = got;
      end
    end
  end

  initial begin
    logic [33:0] got, e;
    forever begin
      @(negedge clk);
      got = {a_vo.tuser, a_vo.tlast, a_vo.tdata};
      if (!rst && a_vo.tvalid && a_vo.tready) begin
        if (a_exp_q.size() != 0) e = a_exp_q.pop_front();
        else e = '1;
        check("auto_out_beat", got, e);
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input bit sel, input logic [31:0] d, input bit last, input bit user);
    int n;
    if (sel) begin
      a_vi.tdata = d; a_vi.tlast = last; a_vi.tuser = user; a_vi.tvalid = 1'b1;
    end else begin
      vi.tdata = d; vi.tlast = last; vi.tuser = user; vi.tvalid = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? a_vi.tready : vi.tready) && n < 2000);
    if (n >= 2000) check("wr_tready_timeout", 64'(sel ? a_vi.tready : vi.tready), 1);
    @(posedge clk);
    #1;
    if (sel) begin
      a_vi.tvalid = 1'b0; a_vi.tlast = 1'b0; a_vi.tuser = 1'b0;
    end else begin
      vi.tvalid = 1'b0; vi.tlast = 1'b0; vi.tuser = 1'b0;
    end
  endtask

  task automatic write_line(input bit sel, input int n, input bit sof, input bit keep, input bit drop_last);
    logic [31:0] d;
    int stored;
    stored = (n > MAXL) ? MAXL : n;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      if (keep && i < stored) begin
        if (sel) a_exp_q.push_back(exp_beat(d, i == stored - 1, sof && i == 0));
        else exp_q.push_back(exp_beat(d, i == stored - 1, sof && i == 0));
      end
      if (drop_last && i == n - 1) drop = 1'b1;
      send_beat(sel, d, i == n - 1, sof && i == 0);
      drop = 1'b0;
    end
  endtask

  task automatic pop_line(input bit timed, input int len);
    int first, lastc;
    first = -1;
    lastc = -1;
    pop = 1'b1;
    for (int c = 0; c < 3000 && lastc < 0; c++) begin
      @(negedge clk);
      if (vo.tvalid && first < 0) first = c;
      if (vo.tvalid && vo.tready && vo.tlast) lastc = c;
      if (c == 0) begin
        @(posedge clk);
        #1 pop = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("pop_tlast_seen", 64'(lastc >= 0), 1);
    if (timed) begin
      check("pop_first_vld_cyc", 64'(first), 2);
      check("pop_tlast_cyc", 64'(lastc), 64'(len + 1));
    end
  endtask

  initial begin
    logic [31:0] d;
    int n;
    total = 0; bad = 0; rdy_mode = 1;
    rst = 1'b1; pop = 1'b0; drop = 1'b0; a_pop = 1'b0; a_drop = 1'b0;
    vi.tvalid = 1'b0; vi.tdata = '0; vi.tlast = 1'b0; vi.tuser = 1'b0;
    a_vi.tvalid = 1'b0; a_vi.tdata = '0; a_vi.tlast = 1'b0; a_vi.tuser = 1'b0;
    a_vo.tready = 1'b0;

    settle(3);
    check("rst_lines", 64'(lines), 0);
    check("rst_empty", 64'(empty), 1);
    check("rst_full", 64'(full), 0);
    check("rst_tvalid", 64'(vo.tvalid), 0);
    check("rst_tlast", 64'(vo.tlast), 0);
    check("rst_tuser", 64'(vo.tuser), 0);
    rst = 1'b0;
    settle(1);
    check("rel_tready", 64'(vi.tready), 1);

    // Three lines, popped one at a time
    write_line(0, 8, 1, 1, 0);
    write_line(0, 8, 0, 1, 0);
    write_line(0, 8, 0, 1, 0);
    check("three_lines", 64'(lines), 3);
    pop_line(1, 8); check("lines_after_pop1", 64'(lines), 2);
    pop_line(1, 8); check("lines_after_pop2", 64'(lines), 1);
    pop_line(1, 8); check("lines_after_pop3", 64'(lines), 0);
    check("empty_after_pops", 64'(empty), 1);

    // Fill all slots, then free one for the fifth line
    for (int k = 0; k < 4; k++) write_line(0, 5, 0, 1, 0);
    check("full_flag", 64'(full), 1);
    check("full_tready", 64'(vi.tready), 0);
    check("full_lines", 64'(lines), 4);
    pop_line(1, 5);
    check("after_free_tready", 64'(vi.tready), 1);
    write_line(0, 5, 0, 1, 0);
    for (int k = 0; k < 4; k++) pop_line(1, 5);
    check("wrap_empty", 64'(lines), 0);

    // Over-long line is truncated
    write_line(0, MAXL + 3, 0, 1, 0);
    pop_line(1, MAXL);

    // Random backpressure
    rdy_mode = 2;
    write_line(0, 10, 0, 1, 0);
    write_line(0, 10, 0, 1, 0);
    pop_line(0, 10);
    pop_line(0, 10);
    rdy_mode = 1;
    settle(2);

    // Drops: simultaneous with write-complete, priority over pop, pop while empty
    write_line(0, 5, 0, 0, 0);
    write_line(0, 4, 0, 1, 1);
    check("drop_with_write_lines", 64'(lines), 1);
    write_line(0, 3, 0, 0, 0);
    check("two_lines", 64'(lines), 2);
    pop_line(1, 4);
    check("after_pop_b", 64'(lines), 1);
    drop = 1'b1; pop = 1'b1;
    settle(1);
    drop = 1'b0; pop = 1'b0;
    check("drop_over_pop_lines", 64'(lines), 0);
    settle(5);
    check("drop_over_pop_vld", 64'(vo.tvalid), 0);
    pop = 1'b1;
    settle(1);
    pop = 1'b0;
    settle(4);
    check("pop_empty_vld", 64'(vo.tvalid), 0);

    // SOF arriving while a line is being read out
    write_line(0, 6, 1, 1, 0);
    write_line(0, 6, 0, 0, 0);
    pop_line(1, 6);
    rdy_mode = 0;
    settle(2);
    pop = 1'b1;
    settle(1);
    pop = 1'b0;
    settle(4);
    check("stalled_vld", 64'(vo.tvalid), 1);
    d = $urandom;
    exp_q.push_back(exp_beat(d, 0, 1));
    send_beat(0, d, 0, 1);
    check("sof_abort_vld", 64'(vo.tvalid), 0);
    check("sof_abort_lines", 64'(lines), 0);
    for (int i = 1; i < 4; i++) begin
      d = $urandom;
      exp_q.push_back(exp_beat(d, i == 3, 0));
      send_beat(0, d, i == 3, 0);
    end
    check("sof_line_lines", 64'(lines), 1);
    rdy_mode = 1;
    settle(2);
    pop_line(1, 4);

    // Reset in the middle of a transfer
    write_line(0, 8, 0, 0, 0);
    rdy_mode = 0;
    settle(2);
    pop = 1'b1;
    settle(1);
    pop = 1'b0;
    settle(4);
    rst = 1'b1;
    #1;
    check("midrst_vld", 64'(vo.tvalid), 0);
    check("midrst_lines", 64'(lines), 0);
    settle(2);
    rst = 1'b0;
    settle(1);
    check("midrst_tready", 64'(vi.tready), 1);
    check("midrst_empty", 64'(empty), 1);
    rdy_mode = 1;
    settle(20);
    check("midrst_no_beat", 64'(vo.tvalid), 0);

    // Auto-pop instance: the second of three lines is dropped
    write_line(1, 5, 0, 1, 0);
    write_line(1, 5, 0, 0, 0);
    write_line(1, 5, 0, 1, 0);
    check("auto_lines", 64'(a_lines), 3);
    check("auto_started", 64'(a_vo.tvalid), 1);
    a_vo.tready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_vo.tvalid && a_vo.tready && a_vo.tlast) && n < 200);
    check("auto_line1_done", 64'(a_vo.tvalid && a_vo.tlast), 1);
    @(posedge clk);
    #1 a_drop = 1'b1;
    @(posedge clk);
    #1 a_drop = 1'b0;
    check("auto_after_drop", 64'(a_lines), 1);
    n = 0;
    while (!a_empty && n < 200) begin
      settle(1);
      n++;
    end
    settle(3);
    check("auto_empty", 64'(a_empty), 1);

    check("sb_drained", 64'(exp_q.size()), 0);
    check("auto_sb_drained", 64'(a_exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
